// File: rtl/m65_bus_pkg.sv
// m65_bus_pkg: FSM states, bus owner encodings and requester IDs for the CPU/DMA bus slot arbiter
package m65_bus_pkg;
    typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_DMA} arb_state_t;
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_DMA  = 2'b10;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/m65_slot_credit.sv
// m65_slot_credit: single-bit paced slot credit with full_speed override and saturating missed-slot counter
module m65_slot_credit #(
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_step,
    input  logic              consume,
    input  logic              full_speed,
    output logic              credit,
    output logic [MISS_W-1:0] slot_miss_count
);
    logic credit_q;
    logic miss;
    always_comb begin
        credit = credit_q | slot_step | full_speed;
        miss   = slot_step & credit_q & ~consume;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q        <= 1'b0;
            slot_miss_count <= '0;
        end else begin
            credit_q <= (credit_q & slot_step) | ((credit_q | slot_step) & ~consume);
            if (miss && !(&slot_miss_count))
                slot_miss_count <= slot_miss_count + 1'b1;
        end
    end
endmodule

// File: rtl/m65_bus_slot_arb.sv
// m65_bus_slot_arb: grants at most one CPU or DMA bus cycle per paced slot, DMA priority with CPU anti-starvation
module m65_bus_slot_arb
    import m65_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int MISS_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_step,
    input  logic              full_speed,
    input  logic              dma_priority,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic              bus_ready,
    input  logic              mapper_busy,
    output logic              cpu_grant,
    output logic              dma_grant,
    output logic              cpu_ack,
    output logic              dma_ack,
    output logic [1:0]        bus_owner,
    output logic [MISS_W-1:0] slot_miss_count
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    arb_state_t state, state_nxt;
    logic       credit;
    logic       consume;
    logic       dma_wins;
    logic       last_winner;
    logic [7:0] starve_cnt;

    m65_slot_credit #(.MISS_W(MISS_W)) u_credit (
        .clk             (clk),
        .reset           (reset),
        .slot_step       (slot_step),
        .consume         (consume),
        .full_speed      (full_speed),
        .credit          (credit),
        .slot_miss_count (slot_miss_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            last_winner <= REQ_DMA;
        end else if (consume) begin
            last_winner <= dma_wins ? REQ_DMA : REQ_CPU;
            starve_cnt  <= !dma_wins ? '0 :
                           (cpu_req && starve_cnt != LIMIT) ? starve_cnt + 8'd1 : starve_cnt;
        end
    end

    // A tie goes to DMA under priority until the CPU has lost LIMIT times in a row
    always_comb begin
        consume   = (state == IDLE) & credit & (cpu_req | dma_req);
        dma_wins  = dma_req & (~cpu_req | (dma_priority ? (starve_cnt != LIMIT) : (last_winner == REQ_CPU)));
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = consume ? (dma_wins ? GRANT_DMA : GRANT_CPU) : IDLE;
            GRANT_CPU: state_nxt = cpu_ack ? IDLE : GRANT_CPU;
            GRANT_DMA: state_nxt = dma_ack ? IDLE : GRANT_DMA;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_grant = state == GRANT_CPU;
        dma_grant = state == GRANT_DMA;
        cpu_ack   = cpu_grant & bus_ready & ~mapper_busy;
        dma_ack   = dma_grant & bus_ready & ~mapper_busy;
        bus_owner = cpu_grant ? OWNER_CPU : dma_grant ? OWNER_DMA : OWNER_NONE;
    end
endmodule

// File: tb/tb_m65_bus_slot_arb.sv
// tb_m65_bus_slot_arb: scoreboarded grant order plus directed cycle checks for the bus slot arbiter
module tb_m65_bus_slot_arb;
    import m65_bus_pkg::*;
    logic       clk, reset, slot_step, full_speed, dma_priority;
    logic       cpu_req, dma_req, bus_ready, mapper_busy;
    logic       cpu_grant, dma_grant, cpu_ack, dma_ack;
    logic [1:0] bus_owner;
    logic [7:0] slot_miss_count;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_start = -1;
    bit         chk_spacing = 0;
    logic [1:0] prev_owner = OWNER_NONE;
    logic [1:0] sb[$];

    m65_bus_slot_arb #(.STARVE_LIMIT(3), .MISS_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .slot_step       (slot_step),
        .full_speed      (full_speed),
        .dma_priority    (dma_priority),
        .cpu_req         (cpu_req),
        .dma_req         (dma_req),
        .bus_ready       (bus_ready),
        .mapper_busy     (mapper_busy),
        .cpu_grant       (cpu_grant),
        .dma_grant       (dma_grant),
        .cpu_ack         (cpu_ack),
        .dma_ack         (dma_ack),
        .bus_owner       (bus_owner),
        .slot_miss_count (slot_miss_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; cpu_req = 0; dma_req = 0; slot_step = 0;
        repeat (2) tick();
        reset = 0;
    endtask

    // Each new grant is matched against the expected owner order
    always @(negedge clk) begin
        if (!chk_spacing) last_start = -1;
        if (bus_owner != OWNER_NONE && prev_owner == OWNER_NONE) begin
            if (sb.size() == 0) check("sb_extra_grant", 32'(bus_owner), 32'(OWNER_NONE));
            else check("sb_owner", 32'(bus_owner), 32'(sb.pop_front()));
            if (chk_spacing && last_start >= 0) check("grant_spacing", cyc - last_start, 2);
            last_start = cyc;
        end
        prev_owner = bus_owner;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; slot_step = 0; full_speed = 0; dma_priority = 0;
        cpu_req = 0; dma_req = 0; bus_ready = 0; mapper_busy = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_grants", {30'd0, cpu_grant, dma_grant}, 0);
        check("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
        check("rst_owner", 32'(bus_owner), 32'(OWNER_NONE));
        check("rst_miss", 32'(slot_miss_count), 0);
        tick();
        reset = 0;

        // single CPU request paced by one slot
        bus_ready = 1; cpu_req = 1;
        repeat (4) tick();
        @(negedge clk);
        check("s1_no_credit", 32'(cpu_grant), 0);
        tick();
        slot_step = 1; sb.push_back(OWNER_CPU);
        tick();
        slot_step = 0;
        @(negedge clk);
        check("s1_grant_ack", {30'd0, cpu_grant, cpu_ack}, 2'b11);
        check("s1_owner", 32'(bus_owner), 32'(OWNER_CPU));
        tick();
        cpu_req = 0;
        @(negedge clk);
        check("s1_release", {29'd0, cpu_grant, bus_owner}, 0);
        check("s1_drain", sb.size(), 0);

        // round robin at full speed
        do_reset();
        dma_priority = 0; full_speed = 1; chk_spacing = 1;
        sb.push_back(OWNER_CPU); sb.push_back(OWNER_DMA); sb.push_back(OWNER_CPU); sb.push_back(OWNER_DMA);
        cpu_req = 1; dma_req = 1;
        repeat (8) tick();
        cpu_req = 0; dma_req = 0;
        repeat (2) tick();
        chk_spacing = 0; full_speed = 0;
        check("s2_drain", sb.size(), 0);

        // DMA priority with starvation limit 3
        do_reset();
        dma_priority = 1; full_speed = 1; chk_spacing = 1;
        sb.push_back(OWNER_DMA); sb.push_back(OWNER_DMA); sb.push_back(OWNER_DMA);
        sb.push_back(OWNER_CPU); sb.push_back(OWNER_DMA);
        cpu_req = 1; dma_req = 1;
        repeat (10) tick();
        cpu_req = 0; dma_req = 0;
        repeat (2) tick();
        chk_spacing = 0; full_speed = 0; dma_priority = 0;
        check("s3_drain", sb.size(), 0);

        // mapper stall holds the CPU grant while a DMA request waits
        do_reset();
        bus_ready = 1; mapper_busy = 1; cpu_req = 1; slot_step = 1;
        sb.push_back(OWNER_CPU);
        tick();
        slot_step = 0; dma_req = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("s4_stall", {29'd0, cpu_grant, cpu_ack, dma_grant}, 3'b100);
            tick();
        end
        mapper_busy = 0; slot_step = 1;
        sb.push_back(OWNER_DMA);
        @(negedge clk);
        check("s4_ack", {29'd0, cpu_grant, cpu_ack, dma_grant}, 3'b110);
        tick();
        slot_step = 0; cpu_req = 0;
        @(negedge clk);
        check("s4_idle", {30'd0, cpu_grant, dma_grant}, 0);
        tick();
        @(negedge clk);
        check("s4_dma_grant_ack", {30'd0, dma_grant, dma_ack}, 2'b11);
        tick();
        dma_req = 0;
        check("s4_drain", sb.size(), 0);

        // missed slots with no requests pending
        do_reset();
        repeat (5) begin
            slot_step = 1; tick();
            slot_step = 0; tick();
        end
        @(negedge clk);
        check("s5_miss4", 32'(slot_miss_count), 4);
        tick();
        cpu_req = 1; sb.push_back(OWNER_CPU);
        @(negedge clk);
        check("s5_not_yet", 32'(cpu_grant), 0);
        tick();
        @(negedge clk);
        check("s5_credit_grant", 32'(cpu_grant), 1);
        tick();
        cpu_req = 0; slot_step = 1;
        repeat (300) tick();
        slot_step = 0;
        @(negedge clk);
        check("s5_miss_sat", 32'(slot_miss_count), 255);

        // reset while DMA owns the bus
        dma_req = 1; bus_ready = 0; slot_step = 1;
        sb.push_back(OWNER_DMA);
        tick();
        slot_step = 0;
        @(negedge clk);
        check("s6_dma_held", {30'd0, dma_grant, dma_ack}, 2'b10);
        tick();
        reset = 1; dma_req = 0;
        tick();
        reset = 0; cpu_req = 1; bus_ready = 1;
        @(negedge clk);
        check("s6_grants", {30'd0, cpu_grant, dma_grant}, 0);
        check("s6_owner", 32'(bus_owner), 32'(OWNER_NONE));
        check("s6_miss", 32'(slot_miss_count), 0);
        repeat (3) tick();
        @(negedge clk);
        check("s6_credit_clear", 32'(cpu_grant), 0);
        tick();
        cpu_req = 0;
        check("s6_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
